// File: rtl/dca_step_issue_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | dca_step_issue_ctrl_pkg                                                     |
// | Opcode bit layout and FSM state encodings for the DCA step-issue controller |
// | Rev 1.0 - initial N-channel / sized-credit release                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package dca_step_issue_ctrl_pkg;

  // Opcode lives in inst[BW_OPCODE-1:0]; LOAD_REQ occupies the top NUM_LOAD_CH bits.
  localparam int c_OP_NO_CAL    = 0;
  localparam int c_OP_LOAD_ACC  = 1;
  localparam int c_OP_STORE_REQ = 2;
  localparam int c_OP_DRAIN     = 3;
  localparam int c_OP_LOAD_REQ  = 4;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_EXEC  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  function automatic int bw_opcode(input int num_load_ch);
    return c_OP_LOAD_REQ + num_load_ch;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dca_store_credit_counter.sv
// +----------------------------------------------------------------------------+
// | dca_store_credit_counter                                                    |
// | Outstanding-store counter: +1 on inc, -1 on dec, hold when both or neither |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module dca_store_credit_counter #(
  parameter int STORE_CREDIT = 3,
  parameter int BW_CREDIT    = $clog2(STORE_CREDIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  output logic [BW_CREDIT-1:0] count,
  output logic                 full
);

  logic [BW_CREDIT-1:0] r_count;
  logic                 w_dec;
  logic                 w_inc;

  // An ack with nothing outstanding is dropped; an inc while full only lands if a dec frees a slot.
  assign w_dec = dec & (r_count != '0);
  assign w_inc = inc & (~full | w_dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_inc && !w_dec) begin
      r_count <= r_count + 1'b1;
    end else if (!w_inc && w_dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign full  = (r_count >= BW_CREDIT'(STORE_CREDIT));

endmodule

`default_nettype wire

// File: rtl/dca_step_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | dca_step_issue_ctrl                                                         |
// | Step-issue controller: gates issue on load/MAC/store readiness, retires    |
// | steps with optional store drain. Optional perf counters: DCA_STEP_ISSUE_PERF_EN |
// | Rev 1.0 - initial N-channel / sized-credit release                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module dca_step_issue_ctrl
  import dca_step_issue_ctrl_pkg::*;
#(
  parameter  int NUM_LOAD_CH  = 2,
  parameter  int STORE_CREDIT = 3,
  parameter  int BW_INST      = 64,
  localparam int BW_CREDIT    = $clog2(STORE_CREDIT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  output logic                   busy,
  input  logic                   inst_valid,
  input  logic [BW_INST-1:0]     inst,
  output logic                   inst_ready,
  input  logic [NUM_LOAD_CH-1:0] load_ready,
  output logic [NUM_LOAD_CH-1:0] load_req,
  output logic [NUM_LOAD_CH-1:0] load_fin,
  input  logic                   store_ready,
  output logic                   store_issue,
  input  logic                   store_ack,
  input  logic                   acc_ready,
  output logic                   acc_fin,
  input  logic                   mac_ready,
  output logic                   mac_start,
  output logic [BW_INST-1:0]     mac_inst,
  input  logic                   mac_done,
  output logic                   step_done,
  output logic [BW_CREDIT-1:0]   store_outstanding,
  output logic [31:0]            perf_issue_count,
  output logic [31:0]            perf_stall_count
);

  localparam int BW_OPCODE = bw_opcode(NUM_LOAD_CH);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [BW_OPCODE-1:0]   w_op;
  logic [NUM_LOAD_CH-1:0] w_lreq;
  logic w_no_cal, w_load_acc, w_store_req, w_drain;
  logic w_go, w_idle, w_req_cyc, w_load_ok, w_store_ok, w_full;
  logic w_issue, w_acc_only, w_nop, w_mac_fin, w_drain_exit;

  assign w_op        = inst[BW_OPCODE-1:0];
  assign w_no_cal    = w_op[c_OP_NO_CAL];
  assign w_load_acc  = w_op[c_OP_LOAD_ACC];
  assign w_store_req = w_op[c_OP_STORE_REQ];
  assign w_drain     = w_op[c_OP_DRAIN];
  assign w_lreq      = w_op[c_OP_LOAD_REQ +: NUM_LOAD_CH];

  // clear outranks enable, so it also suppresses every strobe in its cycle.
  assign w_go       = enable & ~clear;
  assign w_idle     = (r_state == c_ST_IDLE);
  assign w_req_cyc  = w_go & w_idle & inst_valid;
  assign w_load_ok  = &(load_ready | ~w_lreq);
  assign w_store_ok = ~w_store_req | (store_ready & ~w_full);

  assign w_issue      = w_req_cyc & ~w_no_cal & mac_ready & w_load_ok & w_store_ok;
  assign w_acc_only   = w_req_cyc & w_no_cal & w_load_acc & acc_ready;
  assign w_nop        = w_req_cyc & w_no_cal & ~w_load_acc;
  assign w_mac_fin    = w_go & (r_state == c_ST_EXEC) & mac_done;
  assign w_drain_exit = w_go & (r_state == c_ST_DRAIN) &
                        ((store_outstanding == '0) |
                         ((store_outstanding == BW_CREDIT'(1)) & store_ack));

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = c_ST_IDLE;
    end else if (w_issue) begin
      w_state_nxt = c_ST_EXEC;
    end else if (w_mac_fin) begin
      w_state_nxt = w_drain ? c_ST_DRAIN : c_ST_IDLE;
    end else if (w_drain_exit) begin
      w_state_nxt = c_ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign busy        = ~w_idle;
  assign inst_ready  = w_issue | w_acc_only | w_nop;
  assign mac_start   = w_issue;
  assign mac_inst    = inst;
  assign load_req    = w_issue ? w_lreq : '0;
  assign load_fin    = w_mac_fin ? w_lreq : '0;
  assign store_issue = w_mac_fin & w_store_req;
  assign acc_fin     = w_acc_only | (w_mac_fin & w_load_acc);
  assign step_done   = (w_mac_fin & ~w_drain) | w_drain_exit;

  dca_store_credit_counter #(
    .STORE_CREDIT (STORE_CREDIT),
    .BW_CREDIT    (BW_CREDIT)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (store_issue),
    .dec   (store_ack),
    .count (store_outstanding),
    .full  (w_full)
  );

`ifdef DCA_STEP_ISSUE_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = enable & w_idle & inst_valid & ~inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else if (clear) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_issue && (r_perf_issue != '1)) r_perf_issue <= r_perf_issue + 32'd1;
      if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issue_count = r_perf_issue;
  assign perf_stall_count = r_perf_stall;
`else
  assign perf_issue_count = '0;
  assign perf_stall_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dca_step_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_dca_step_issue_ctrl                                                      |
// | Scoreboard bench: directed scenarios plus random traffic vs a rule model   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dca_step_issue_ctrl;

  localparam int NL = 2;
  localparam int SC = 3;
  localparam int BI = 64;
  localparam int BC = $clog2(SC + 1);
  localparam int SW = 5 + 2 * NL;

  logic          clk = 1'b0;
  logic          rst, clear, enable, inst_valid;
  logic [BI-1:0] inst;
  logic [NL-1:0] load_ready, load_req, load_fin;
  logic          store_ready, store_issue, store_ack, acc_ready, acc_fin;
  logic          mac_ready, mac_start, mac_done, step_done, busy, inst_ready;
  logic [BI-1:0] mac_inst;
  logic [BC-1:0] store_outstanding;
  logic [31:0]   perf_issue_count, perf_stall_count;

  always #5 clk = ~clk;

  dca_step_issue_ctrl #(.NUM_LOAD_CH(NL), .STORE_CREDIT(SC), .BW_INST(BI)) dut (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .busy(busy),
    .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .load_ready(load_ready), .load_req(load_req), .load_fin(load_fin),
    .store_ready(store_ready), .store_issue(store_issue), .store_ack(store_ack),
    .acc_ready(acc_ready), .acc_fin(acc_fin), .mac_ready(mac_ready),
    .mac_start(mac_start), .mac_inst(mac_inst), .mac_done(mac_done),
    .step_done(step_done), .store_outstanding(store_outstanding),
    .perf_issue_count(perf_issue_count), .perf_stall_count(perf_stall_count)
  );

  typedef struct {
    int            cyc;
    logic [SW-1:0] s;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   started = 1'b0;

  // Reference state: phase 0 = waiting for work, 1 = MAC running, 2 = waiting for stores to drain.
  int            m_phase = 0;
  int            m_out   = 0;
  int            m_issues = 0;
  int            m_stalls = 0;
  bit            m_taken;
  int            s_busy, s_out, s_issues, s_stalls;
  logic [BI-1:0] s_inst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic step(input bit clr, input bit en, input bit v, input logic [BI-1:0] in_i,
                      input logic [NL-1:0] lr, input bit sr, input bit sa, input bit ar,
                      input bit mr, input bit md);
    bit            rdy, ms, si, af, sd, no_cal, lacc, sreq, drn;
    logic [NL-1:0] lreq, lq, lf;
    int            nxt;
    @(posedge clk);
    #1;
    clear = clr; enable = en; inst_valid = v; inst = in_i; load_ready = lr;
    store_ready = sr; store_ack = sa; acc_ready = ar; mac_ready = mr; mac_done = md;
    cyc++;
    started  = 1'b1;
    s_busy   = (m_phase != 0);
    s_out    = m_out;
    s_issues = m_issues;
    s_stalls = m_stalls;
    s_inst   = in_i;
    no_cal = in_i[0]; lacc = in_i[1]; sreq = in_i[2]; drn = in_i[3]; lreq = in_i[4 +: NL];
    rdy = 0; ms = 0; si = 0; af = 0; sd = 0; lq = '0; lf = '0; nxt = m_phase;
    if (!clr && en) begin
      if (m_phase == 0 && v) begin
        if (no_cal) begin
          if (!lacc) rdy = 1;
          else if (ar) begin rdy = 1; af = 1; end
        end else if (mr && ((lr & lreq) == lreq) && (!sreq || (sr && m_out < SC))) begin
          rdy = 1; ms = 1; lq = lreq; nxt = 1;
        end
      end else if (m_phase == 1 && md) begin
        lf = lreq; si = sreq; af = lacc;
        if (drn) nxt = 2;
        else begin sd = 1; nxt = 0; end
      end else if (m_phase == 2 && (m_out == 0 || (m_out == 1 && sa))) begin
        sd = 1; nxt = 0;
      end
    end
    if (clr) nxt = 0;
    if ({rdy, ms, lq, lf, si, af, sd} != '0) q.push_back('{cyc, {rdy, ms, lq, lf, si, af, sd}});
    if (clr) begin
      m_issues = 0; m_stalls = 0;
    end else begin
      if (ms) m_issues++;
      if (en && m_phase == 0 && v && !rdy) m_stalls++;
    end
    m_out   = m_out + int'(si) - int'(sa && m_out > 0);
    m_phase = nxt;
    m_taken = rdy;
  endtask

  // Monitor: pops an expectation whenever the DUT shows any strobe, and tracks status every cycle.
  always @(negedge clk) begin
    logic [SW-1:0] act;
    exp_t          e;
    if (!rst && started) begin
      act = {inst_ready, mac_start, load_req, load_fin, store_issue, acc_fin, step_done};
      if (act != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", 64'(act), 64'd0);
        end else begin
          e = q.pop_front();
          chk("strobes", 64'(act), 64'(e.s));
          chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk("missed_strobe", 64'(act), 64'(e.s));
      end
      chk("busy", 64'(busy), 64'(s_busy));
      chk("store_outstanding", 64'(store_outstanding), 64'(s_out));
      chk("mac_inst", mac_inst, s_inst);
`ifdef DCA_STEP_ISSUE_PERF_EN
      chk("perf_issue", 64'(perf_issue_count), 64'(s_issues));
      chk("perf_stall", 64'(perf_stall_count), 64'(s_stalls));
`else
      chk("perf_issue", 64'(perf_issue_count), 64'd0);
      chk("perf_stall", 64'(perf_stall_count), 64'd0);
`endif
    end
  end

  // Opcode helpers: bit0 NO_CAL, bit1 LOAD_ACC, bit2 STORE_REQ, bit3 DRAIN, bits[5:4] LOAD_REQ.
  localparam logic [BI-1:0] OP_LD11   = 64'h30;
  localparam logic [BI-1:0] OP_ST     = 64'h04;
  localparam logic [BI-1:0] OP_DRN_ST = 64'h0C;
  localparam logic [BI-1:0] OP_ACC    = 64'h03;
  localparam logic [BI-1:0] OP_LD01   = 64'h12;

  initial begin
    bit            hold, v, clr, en, md;
    logic [BI-1:0] cur;
    rst = 1'b1; clear = 0; enable = 0; inst_valid = 0; inst = '0; load_ready = '0;
    store_ready = 0; store_ack = 0; acc_ready = 0; mac_ready = 0; mac_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_count", 64'(store_outstanding), 64'd0);
    chk("reset_strobes", 64'({inst_ready, mac_start, load_req, load_fin, store_issue,
                               acc_fin, step_done}), 64'd0);
    chk("reset_perf", 64'({perf_issue_count, perf_stall_count}), 64'd0);
    rst = 1'b0;

    // Partial load readiness blocks issue; full readiness issues with load_req=11.
    step(0, 1, 1, OP_LD11, 2'b01, 1, 0, 0, 1, 0);
    step(0, 1, 1, OP_LD11, 2'b11, 1, 0, 0, 1, 0);
    step(0, 1, 0, '0, 2'b11, 1, 0, 0, 1, 1);
    // Fill the store credit to 3.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, OP_ST, 2'b00, 1, 0, 0, 1, 0);
      step(0, 1, 0, '0, 2'b00, 1, 0, 0, 1, 1);
    end
    // Stalled at full credit; one ack frees a slot and issue follows next cycle.
    step(0, 1, 1, OP_DRN_ST, 2'b00, 1, 0, 0, 1, 0);
    step(0, 1, 1, OP_DRN_ST, 2'b00, 1, 1, 0, 1, 0);
    step(0, 1, 1, OP_DRN_ST, 2'b00, 1, 0, 0, 1, 0);
    // mac_done with a simultaneous ack keeps the count, then drain down via acks.
    step(0, 1, 0, '0, 2'b00, 1, 1, 0, 1, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, '0, 2'b00, 1, 1, 0, 1, 0);
    step(0, 1, 0, '0, 2'b00, 1, 0, 0, 1, 0);
    // Accumulator-only step waits on acc_ready without becoming busy.
    for (int k = 0; k < 3; k++) step(0, 1, 1, OP_ACC, 2'b00, 1, 0, 0, 1, 0);
    step(0, 1, 1, OP_ACC, 2'b00, 1, 0, 1, 1, 0);
    // clear during EXEC; the late mac_done must be ignored.
    step(0, 1, 1, OP_LD01, 2'b11, 1, 0, 0, 1, 0);
    step(1, 1, 0, '0, 2'b00, 1, 0, 0, 1, 0);
    step(0, 1, 0, '0, 2'b00, 1, 0, 0, 1, 1);
    step(0, 1, 1, OP_ST, 2'b00, 1, 0, 0, 0, 0);
    step(0, 1, 1, OP_ST, 2'b00, 1, 0, 0, 1, 0);
    step(0, 1, 0, '0, 2'b00, 1, 0, 0, 1, 1);

    hold = 0;
    cur  = '0;
    v    = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        v   = ($urandom % 10) < 7;
        cur = {$urandom, $urandom};
        cur[0] = ($urandom % 4) == 0;
      end
      clr = ($urandom % 60) == 0;
      en  = ($urandom % 10) != 0;
      md  = (m_phase != 0) ? (($urandom % 3) == 0) : (!v && (($urandom % 4) == 0));
      step(clr, en, v, cur, NL'($urandom), ($urandom % 10) < 7, ($urandom % 10) < 3,
           ($urandom % 2) == 0, ($urandom % 10) < 7, md);
      hold = v && !m_taken;
    end

    @(posedge clk);
    #1;
    clear = 0; enable = 0; inst_valid = 0; mac_done = 0; store_ack = 0;
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
